// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch over a req/gnt + rvalid port, credit-limited FIFO, redirect flush.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect sets misalign and halts issue until an aligned redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    logic [31:0] fetch_pc, resp_pc, target;
    logic [31:0] data_q [FIFO_DEPTH];
    logic [31:0] pc_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outstanding, count_n, outstanding_n;
    logic [15:0] discard, discard_n;
    logic acc, keep, drop, push, pop, halt_n;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign target = redirect_pc;
    assign halt_n = redirect_valid ? |redirect_pc[1:0] : misalign;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) misalign <= 1'b0;
        else misalign <= halt_n;
`else
    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign halt_n = 1'b0;
`endif

    assign mem_addr    = fetch_pc;
    assign instr_valid = count != '0;
    assign instr       = instr_valid ? data_q[rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr] : 32'd0;

    // outstanding counts live reads only; reads orphaned by a redirect move into discard
    always_comb begin
        acc           = mem_req && mem_gnt;
        keep          = mem_rvalid && discard == '0;
        drop          = mem_rvalid && discard != '0;
        push          = keep && !redirect_valid;
        pop           = instr_valid && instr_ready && !redirect_valid;
        count_n       = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        outstanding_n = redirect_valid ? '0 : outstanding + CW'(acc) - CW'(keep);
        discard_n     = redirect_valid ? discard + 16'(outstanding) + 16'(acc) - 16'(mem_rvalid)
                                       : discard - 16'(drop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            mem_req     <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            mem_req     <= !redirect_valid && !halt_n && (count_n + outstanding_n) < CW'(FIFO_DEPTH);
            count       <= count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (acc) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= resp_pc;
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random memory/decode traffic against a program-order reference of the fetch stream.
module tb_instr_fetch;
    localparam int DEPTH = 2;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
`endif
    logic clk = 1'b0, reset_n = 1'b0;
    logic mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic redirect_valid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [31:0] mem_addr, mem_rdata = 32'd0, redirect_pc = 32'd0, instr, instr_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign;
`endif
    int vectors = 0, miscompares = 0, grants = 0, handshakes = 0, first, g0;
    int unsigned gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
    logic [31:0] pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_pc, exp_addr, exp_pc, prev_addr;
    logic prev_wait = 1'b0;

    instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    // program order restarts at the target: target, target+4, ... (mod 2^32)
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc  = pc;
        exp_addr = pc;
        top_up();
    endtask

    task automatic step(input logic r = 1'b0, input logic [31:0] pc = 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = r;
        redirect_pc    = pc;
        mem_gnt        = mem_req && ($urandom_range(99) < gnt_pct);
        if (pend_q.size() > 0 && $urandom_range(99) < rv_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_at(pend_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        instr_ready = $urandom_range(99) < rdy_pct;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #2;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
        repeat (2) @(posedge clk);
        restart(32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_target();
        return $urandom & ALIGN_MASK & 32'hFFFF_FFFC | ($urandom & ~ALIGN_MASK);
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            pend_q.delete();
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check("req_hold", 32'(mem_req), 32'd1);
                check("addr_hold", mem_addr, prev_addr);
            end
            prev_wait = mem_req && !mem_gnt && !redirect_valid;
            prev_addr = mem_addr;
            if (mem_req && mem_gnt) begin
                check("fetch_addr", mem_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                pend_q.push_back(mem_addr);
                grants++;
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                exp_pc = exp_q.pop_front();
                check("instr_pc", instr_pc, exp_pc);
                check("instr", instr, word_at(exp_pc));
                top_up();
                handshakes++;
            end
            if (redirect_valid) restart(redirect_pc & ALIGN_MASK);
        end
    end

    initial begin
        do_reset();
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) check("t1_first_req", 32'(mem_req), 32'd1);
            if (first == 0 && instr_valid) first = k;
        end
        check("t1_latency", 32'(first), 32'd3);
        repeat (12) step();

        rdy_pct = 0;
        step(1'b1, 32'h40);
        step();
        g0 = grants;
        repeat (12) step();
        check("t2_grants", 32'(grants - g0), 32'(DEPTH));
        check("t2_req_off", 32'(mem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);
        rdy_pct = 100;
        repeat (10) step();

        do_reset();
        gnt_pct = 0;
        rdy_pct = 100;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_req", 32'(mem_req), 32'd1);
            check("t3_addr", mem_addr, 32'h0);
        end
        gnt_pct = 100;
        repeat (10) step();

        rv_pct = 0;
        step(1'b1, 32'h80);
        step();
        g0 = grants;
        repeat (5) step();
        check("t4_inflight", 32'(grants - g0), 32'd2);
        step(1'b1, 32'h100);
        rv_pct = 100;
        repeat (12) step();

        rv_pct = 0;
        step(1'b1, 32'h280);
        repeat (2) step();
        rv_pct = 100;
        step(1'b1, 32'h300);
        check("t5_req", 32'(mem_req), 32'd1);
        check("t5_gnt", 32'(mem_gnt), 32'd1);
        step();
        check("t5_flushed", 32'(instr_valid), 32'd0);
        repeat (12) step();

        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step();

`ifdef IFETCH_ALIGN_CHECK_EN
        step(1'b1, 32'h102);
        step();
        check("t6_misalign", 32'(misalign), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_halt", 32'(mem_req), 32'd0);
        end
        step(1'b1, 32'h200);
        step();
        check("t6_clear", 32'(misalign), 32'd0);
        repeat (12) step();
`else
        step(1'b1, 32'h102);
        repeat (12) step();
`endif

        for (int s = 0; s < 20; s++) begin
            gnt_pct = $urandom_range(100, 20);
            rv_pct  = $urandom_range(100, 20);
            rdy_pct = $urandom_range(100, 10);
            if (s == 10) do_reset();
            for (int c = 0; c < 100; c++)
                if ($urandom_range(99) < 4) step(1'b1, rnd_target());
                else step();
        end
        gnt_pct = 100;
        rv_pct  = 100;
        rdy_pct = 100;
        repeat (30) step();
        check("progress", 32'(handshakes > 200), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
